// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the CPU and its memory-mapped peripherals.
// Contents:
//   ARCH_DATA_WIDTH  - width of the CPU data bus
//   MMIO_UART_BASE   - TXDATA address of the serial transmitter (STATUS is +1);
//                      the computer's address decoder suppresses RAM writes here
//   uart_state_t     - frame sequencing states of the transmitter
//   UART_STATUS_*    - bit positions inside the transmitter STATUS register
package arch_defs_pkg;

  localparam int ARCH_DATA_WIDTH = 8;

  localparam logic [3:0] MMIO_UART_BASE = 4'hD;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_STATUS_BUSY = 0;
  localparam int UART_STATUS_FULL = 1;
  localparam int UART_STATUS_OVR  = 2;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 and pulses tick for one cycle at the last count,
// then wraps to 0 so consecutive bits follow without a gap.
// Ports:
//   clk     - clock
//   reset   - asynchronous active-low reset
//   restart - synchronous restart; holds the count at 0 while asserted
//   tick    - high during the final cycle of each bit period
module baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  logic [CNT_W-1:0] bit_cnt;

  assign tick = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Free-running bit counter; wraps on tick, pinned to zero by restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (restart || tick) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter (LSB first) with a one-byte holding buffer.
// A store to BASE_ADDR queues a byte; a load from BASE_ADDR+1 returns
// {5'b0, ovr, hold_full, busy} and clears the sticky overrun flag.
// Ports:
//   clk      - clock
//   reset    - asynchronous active-low reset
//   addr     - bus address
//   data_in  - bus write data
//   we       - bus write strobe
//   re       - bus read strobe
//   data_out - read data, zero unless a STATUS read is decoded (OR-mergeable)
//   tx       - serial line, idles high
//   busy     - frame in flight or byte buffered
module mmio_uart_tx
  import arch_defs_pkg::*;
#(
  parameter int                    DATA_WIDTH   = ARCH_DATA_WIDTH,
  parameter int                    ADDR_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(MMIO_UART_BASE),
  parameter int                    CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  tx,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + 1'b1;

  uart_state_t state, state_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  hold, hold_n;
  logic        hold_full, hold_full_n;
  logic        ovr, ovr_n;

  logic        tick;
  logic        wr_data;
  logic        rd_status;
  logic        end_stop;
  logic [7:0]  wr_byte;
  logic [7:0]  status;

  assign wr_data   = we && (addr == BASE_ADDR);
  assign rd_status = re && (addr == STATUS_ADDR);
  assign wr_byte   = data_in[7:0];
  assign end_stop  = (state == STOP) && tick;
  assign busy      = (state != IDLE) || hold_full;

  // The bit timer is held at zero while idle so an accepted write always
  // starts a full-length start bit; chained frames reuse the natural wrap.
  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(state == IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      ovr       <= ovr_n;
    end
  end

  // Frame sequencing plus buffer management. Write handling comes after the
  // state case so that a store landing on the edge that ends a stop bit sees
  // the holding buffer already emptied by the transfer into shreg. The
  // overrun set also comes after the read-clear so a same-edge overrun wins.
  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    ovr_n       = ovr && !rd_status;

    unique case (state)
      IDLE: begin
        if (wr_data) begin
          shreg_n = wr_byte;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (hold_full) begin
            shreg_n     = hold;
            hold_full_n = 1'b0;
            state_n     = START;
          end else if (wr_data) begin
            shreg_n = wr_byte;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (wr_data && (state != IDLE)) begin
      if (end_stop) begin
        if (hold_full) begin
          hold_n      = wr_byte;
          hold_full_n = 1'b1;
        end
      end else if (!hold_full) begin
        hold_n      = wr_byte;
        hold_full_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end
  end

  // Serial line is decoded from state so reset forces it high asynchronously.
  always_comb begin
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    status                   = '0;
    status[UART_STATUS_BUSY] = busy;
    status[UART_STATUS_FULL] = hold_full;
    status[UART_STATUS_OVR]  = ovr;
    data_out                 = '0;
    if (rd_status) begin
      data_out[7:0] = status;
    end
  end

endmodule
